mole_field: RTL and testbench
=============================

# mole_field

Parametrised whack-a-mole round controller: the next generation of the game's mole-driving logic. It owns its own round timer and game state machine, lights a random subset of N_MOLES LEDs per round, detects whacks as switch toggles, awards time-weighted points for hits, counts misses, and sequences a fixed number of rounds separated by dark gaps. It sits between the PRBS generator (random pattern), the board switches, and the LED/score display logic.

## Interface
Parameters:
- N_MOLES, 10, number of moles/switches/LEDs
- ROUND_CYCLES, 20000000, clock cycles a mole pattern is shown
- GAP_CYCLES, 2000000, dark cycles between rounds (>= 1)
- ROUNDS, 16, rounds per game (>= 1)
- SCORE_W, 8, width of per-hit points; localparam CNT_W = $clog2(ROUND_CYCLES), CNT_W >= SCORE_W

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- start  in  1  begin game; sampled only in IDLE or DONE
- random  in  N_MOLES  pattern from PRBS, sampled on round entry
- switch  in  N_MOLES  board switches, already synchronised
- moles  out  N_MOLES  lit-mole LEDs
- hit_valid  out  1  one-cycle pulse: >=1 hit this cycle
- hit_points  out  SCORE_W  points per mole for the hit cycle
- total_score  out  16  accumulated score, saturating
- miss_count  out  8  whacks on unlit moles, saturating
- round_num  out  8  completed rounds in current game
- busy  out  1  high in SHOW or GAP
- done  out  1  high in DONE

## Operation
- States: IDLE, SHOW, GAP, DONE. All outputs registered.
- Reset (rst=0 at a clock edge): state IDLE; moles, hit_valid, hit_points, total_score, miss_count, round_num, busy, done = 0; timer = 0; sw_q loads switch (no spurious toggles after release). Overrides any state, including mid-SHOW.
- Whack detection: sw_q <= switch every cycle; tog = switch ^ sw_q. Either edge direction is a whack.
- IDLE/DONE + start: total_score, miss_count, round_num cleared; enter SHOW.
- SHOW entry: moles <= random, or {0..,1} if random == 0; timer <= ROUND_CYCLES-1.
- In SHOW each cycle: hits = tog & moles; misses = tog & ~moles.
  - pts = timer[CNT_W-1 -: SCORE_W], forced to 1 if 0.
  - hits != 0: moles <= moles & ~hits; hit_valid <= 1; hit_points <= pts; total_score += pts * popcount(hits), saturate at 16'hFFFF.
  - miss_count += popcount(misses), saturate at 8'hFF.
  - Exit to GAP when timer == 0 or (moles & ~hits) == 0; else timer decrements.
- GAP entry: moles <= 0; timer <= GAP_CYCLES-1. Every toggle counts as a miss. At timer == 0: round_num += 1; if new round_num == ROUNDS go DONE, else SHOW.
- DONE: moles 0, scores held, done=1, until start or reset.
- start outside IDLE/DONE ignored.

## Timing
- start sampled at edge t in IDLE -> state SHOW, moles = random(t) at t+1.
- SHOW lasts exactly ROUND_CYCLES cycles unless cleared early; GAP lasts exactly GAP_CYCLES.
- Toggle visible at edge t -> moles bit clear, hit_valid/hit_points, total_score and miss_count updated at t+1. hit_valid is high for one cycle per hit cycle; held toggles (switch static) produce nothing further.
- Hit on the last lit mole in the same cycle timer == 0: hit scored, GAP at t+1.
- Simultaneous hits and misses in one cycle: both counted.
- Lit moles left at SHOW timeout: no penalty, simply cleared.

## Test plan
Params for bench: N_MOLES=4, ROUND_CYCLES=16 (CNT_W=4), GAP_CYCLES=4, ROUNDS=2, SCORE_W=2.
- Hold rst=0 two cycles with switch=4'b1010, release, switch static -> all outputs 0, IDLE, no hit_valid, miss_count 0.
- start with random=4'b0101 -> next cycle moles=0101, busy=1; toggle switch[0] when timer=14 -> hit_points=3, total_score=3, moles=0100, hit_valid one cycle.
- Toggle switch[1] (unlit) and switch[2] (lit) same cycle at timer=5 -> hit_points=1, total +1, miss_count +1, moles=0000, GAP next cycle.
- random=0 at round entry -> moles=0001; no whacks -> SHOW 16 cycles, GAP 4 cycles with moles=0, round_num=1, new pattern loaded.
- Toggles on bits 0 and 2 (both lit) at timer=0 -> hit_points=1, total +2, GAP next cycle; after round 2 -> done=1, scores held; start -> total_score, miss_count, round_num = 0, SHOW.
- rst=0 mid-SHOW with moles=0110 and score 5 -> next cycle all outputs 0, IDLE; start ignored in SHOW/GAP.

Source files
------------

// File: rtl/mole_field.sv
// Whack-a-mole round controller: owns the round/gap timer and game FSM, lights a
// random mole pattern per round, scores time-weighted hits and counts misses.
module mole_field #(
  parameter int N_MOLES      = 10,
  parameter int ROUND_CYCLES = 20000000,
  parameter int GAP_CYCLES   = 2000000,
  parameter int ROUNDS       = 16,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_MOLES-1:0] random,
  input  logic [N_MOLES-1:0] switch,
  output logic [N_MOLES-1:0] moles,
  output logic               hit_valid,
  output logic [SCORE_W-1:0] hit_points,
  output logic [15:0]        total_score,
  output logic [7:0]         miss_count,
  output logic [7:0]         round_num,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
);

  localparam int CNT_W  = $clog2(ROUND_CYCLES);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TMR_W  = (CNT_W > GAP_W) ? CNT_W : GAP_W;
  localparam int PC_W   = $clog2(N_MOLES + 1);
  localparam int PROD_W = SCORE_W + PC_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic [N_MOLES-1:0] sw_q;
  logic [N_MOLES-1:0] moles_n;
  logic               hit_valid_n;
  logic [SCORE_W-1:0] hit_points_n;
  logic [15:0]        total_n;
  logic [7:0]         miss_n;
  logic [7:0]         round_n;

  logic [N_MOLES-1:0] tog, hits, misses, remaining, pattern;
  logic [SCORE_W-1:0] pts;
  logic [PC_W-1:0]    hit_cnt, miss_cnt, tog_cnt;
  logic [PROD_W-1:0]  prod;
  logic [16:0]        score_sum;
  logic [8:0]         miss_show_sum, miss_gap_sum;
  logic [7:0]         round_inc;

  function automatic logic [PC_W-1:0] popcount(input logic [N_MOLES-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_MOLES; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  assign state_dbg = state;

  // Either switch edge is a whack; sw_q is reloaded in reset so release is quiet.
  always_comb begin
    tog       = switch ^ sw_q;
    hits      = tog & moles;
    misses    = tog & ~moles;
    remaining = moles & ~hits;
    pattern   = (random == '0) ? N_MOLES'(1) : random;
    pts       = timer[CNT_W-1 -: SCORE_W];
    if (pts == '0) pts = SCORE_W'(1);
    hit_cnt       = popcount(hits);
    miss_cnt      = popcount(misses);
    tog_cnt       = popcount(tog);
    prod          = PROD_W'(pts) * PROD_W'(hit_cnt);
    score_sum     = {1'b0, total_score} + 17'(prod);
    miss_show_sum = {1'b0, miss_count} + 9'(miss_cnt);
    miss_gap_sum  = {1'b0, miss_count} + 9'(tog_cnt);
    round_inc     = round_num + 8'd1;
  end

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    moles_n      = moles;
    hit_valid_n  = 1'b0;
    hit_points_n = '0;
    total_n      = total_score;
    miss_n       = miss_count;
    round_n      = round_num;
    case (state)
      S_IDLE, S_DONE: begin
        moles_n = '0;
        if (start) begin
          total_n = '0;
          miss_n  = '0;
          round_n = '0;
          state_n = S_SHOW;
          moles_n = pattern;
          timer_n = TMR_W'(ROUND_CYCLES - 1);
        end
      end
      S_SHOW: begin
        if (hits != '0) begin
          moles_n      = remaining;
          hit_valid_n  = 1'b1;
          hit_points_n = pts;
          total_n      = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
        miss_n = miss_show_sum[8] ? 8'hFF : miss_show_sum[7:0];
        // Clearing the last mole ends the round early, even on the final cycle.
        if (timer == '0 || remaining == '0) begin
          state_n = S_GAP;
          moles_n = '0;
          timer_n = TMR_W'(GAP_CYCLES - 1);
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      S_GAP: begin
        miss_n = miss_gap_sum[8] ? 8'hFF : miss_gap_sum[7:0];
        if (timer == '0) begin
          round_n = round_inc;
          if (round_inc == 8'(ROUNDS)) begin
            state_n = S_DONE;
          end else begin
            state_n = S_SHOW;
            moles_n = pattern;
            timer_n = TMR_W'(ROUND_CYCLES - 1);
          end
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    sw_q <= switch;
    if (!rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      moles       <= '0;
      hit_valid   <= 1'b0;
      hit_points  <= '0;
      total_score <= '0;
      miss_count  <= '0;
      round_num   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      moles       <= moles_n;
      hit_valid   <= hit_valid_n;
      hit_points  <= hit_points_n;
      total_score <= total_n;
      miss_count  <= miss_n;
      round_num   <= round_n;
      busy        <= (state_n == S_SHOW) || (state_n == S_GAP);
      done        <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_mole_field.sv
// Directed bench for mole_field: hit-point values are queued when a whack is driven
// and popped whenever the DUT pulses hit_valid; state/score outputs checked directly.
module tb_mole_field;

  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  random;
  logic [N-1:0]  switch;
  logic [N-1:0]  moles;
  logic          hit_valid;
  logic [SW-1:0] hit_points;
  logic [15:0]   total_score;
  logic [7:0]    miss_count;
  logic [7:0]    round_num;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [SW-1:0] exp_q[$];

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  mole_field #(
    .N_MOLES(N), .ROUND_CYCLES(16), .GAP_CYCLES(4), .ROUNDS(2), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .random(random), .switch(switch),
    .moles(moles), .hit_valid(hit_valid), .hit_points(hit_points),
    .total_score(total_score), .miss_count(miss_count), .round_num(round_num),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_moles"}, moles, 0);
    check({tag, "_hv"}, hit_valid, 0);
    check({tag, "_hp"}, hit_points, 0);
    check({tag, "_total"}, total_score, 0);
    check({tag, "_miss"}, miss_count, 0);
    check({tag, "_round"}, round_num, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // scoreboard: every hit_valid pulse must match the next queued point value
  always @(negedge clk) begin
    if (hit_valid === 1'b1) begin
      if (exp_q.size() == 0) check("hit_unexpected", hit_valid, 0);
      else check("hit_points_q", hit_points, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; random = '0; switch = 4'b1010;
    step(2);
    check_cleared("reset");
    rst = 1'b1;
    step(2);
    check_cleared("release");

    // game 1, round 1
    random = 4'b0101; start = 1'b1;
    step(1);
    start = 1'b0;
    check("r1_moles", moles, 4'b0101);
    check("r1_busy", busy, 1);
    check("r1_state", state_dbg, ST_SHOW);
    step(1);
    switch ^= 4'b0001; exp_q.push_back(2'd3);
    step(1);
    check("hit14_hv", hit_valid, 1);
    check("hit14_total", total_score, 3);
    check("hit14_moles", moles, 4'b0100);
    check("hit14_miss", miss_count, 0);
    step(1);
    check("hv_pulse", hit_valid, 0);
    step(7);
    switch ^= 4'b0110; exp_q.push_back(2'd1);
    step(1);
    check("mix_hp", hit_points, 1);
    check("mix_total", total_score, 4);
    check("mix_miss", miss_count, 1);
    check("mix_moles", moles, 0);
    check("mix_state", state_dbg, ST_GAP);

    // gap toggles are misses; next round loads a zero pattern
    random = '0;
    step(1);
    switch ^= 4'b1000;
    step(1);
    check("gap_miss", miss_count, 2);
    check("gap_busy", busy, 1);
    step(2);
    check("r2_state", state_dbg, ST_SHOW);
    check("r2_moles", moles, 4'b0001);
    check("r2_round", round_num, 1);
    step(15);
    check("r2_last_show", state_dbg, ST_SHOW);
    check("r2_last_moles", moles, 4'b0001);
    step(1);
    check("r2_timeout", state_dbg, ST_GAP);
    check("r2_timeout_moles", moles, 0);
    check("r2_timeout_miss", miss_count, 2);
    step(3);
    check("r2_gap_hold", state_dbg, ST_GAP);
    step(1);
    check("done_state", state_dbg, ST_DONE);
    check("done_flag", done, 1);
    check("done_busy", busy, 0);
    check("done_round", round_num, 2);
    check("done_total", total_score, 4);
    switch ^= 4'b0001;
    step(2);
    check("done_miss_held", miss_count, 2);
    check("done_total_held", total_score, 4);
    check("done_still", done, 1);

    // game 2
    random = 4'b0111; start = 1'b1;
    step(1);
    start = 1'b0;
    check("g2_total", total_score, 0);
    check("g2_miss", miss_count, 0);
    check("g2_round", round_num, 0);
    check("g2_moles", moles, 4'b0111);
    check("g2_done", done, 0);
    step(1);
    switch ^= 4'b0010; exp_q.push_back(2'd3);
    step(1);
    check("g2_hit_total", total_score, 3);
    check("g2_hit_moles", moles, 4'b0101);
    step(13);
    switch ^= 4'b0101; exp_q.push_back(2'd1);
    step(1);
    check("t0_total", total_score, 5);
    check("t0_hp", hit_points, 1);
    check("t0_moles", moles, 0);
    check("t0_state", state_dbg, ST_GAP);
    random = 4'b0110; start = 1'b1;
    step(1);
    start = 1'b0;
    check("gap_start_state", state_dbg, ST_GAP);
    check("gap_start_total", total_score, 5);
    step(3);
    check("g2r2_state", state_dbg, ST_SHOW);
    check("g2r2_moles", moles, 4'b0110);
    check("g2r2_round", round_num, 1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("show_start_state", state_dbg, ST_SHOW);
    check("show_start_total", total_score, 5);
    check("show_start_moles", moles, 4'b0110);

    // reset mid-SHOW
    rst = 1'b0;
    step(1);
    check_cleared("mid_rst");
    rst = 1'b1;
    step(2);
    check("post_rst_state", state_dbg, ST_IDLE);
    check("post_rst_hv", hit_valid, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
